// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode encoding and the illegal-opcode test.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    AluAdd  = 4'h0,
    AluSll,
    AluSlt,
    AluSltu,
    AluXor,
    AluSrl,
    AluOr,
    AluAnd,
    AluSub,
    AluNeq,
    AluEq,
    AluGe,
    AluGeu,
    AluSra
  } alu_op_e;

  function automatic logic is_illegal_op(logic [3:0] sel);
    return sel >= 4'hE;
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU; opcodes 0xE/0xF produce 0.
module alu import alu_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      sel,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  output logic [XLEN-1:0] dataD
);

  // Clock and reset exist for port compatibility only; the datapath is stateless.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  logic [4:0] shamt;
  assign shamt = dataB[4:0];

  always_comb begin
    dataD = '0;
    case (sel)
      AluAdd:  dataD = dataA + dataB;
      AluSll:  dataD = dataA << shamt;
      AluSlt:  dataD = {31'b0, $signed(dataA) < $signed(dataB)};
      AluSltu: dataD = {31'b0, dataA < dataB};
      AluXor:  dataD = dataA ^ dataB;
      AluSrl:  dataD = dataA >> shamt;
      AluOr:   dataD = dataA | dataB;
      AluAnd:  dataD = dataA & dataB;
      AluSub:  dataD = dataA - dataB;
      AluNeq:  dataD = {31'b0, dataA != dataB};
      AluEq:   dataD = {31'b0, dataA == dataB};
      AluGe:   dataD = {31'b0, $signed(dataA) >= $signed(dataB)};
      AluGeu:  dataD = {31'b0, dataA >= dataB};
      AluSra:  dataD = $signed(dataA) >>> shamt;
      default: dataD = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic found;

  // Pass one covers [ptr, NUM_REQ), pass two the wrapped range [0, ptr).
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i] && (ID_W'(i) >= ptr)) begin
        found = 1'b1;
        idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = ID_W'(i);
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters with a registered result.
// Define ALU_ARB_ILLEGAL_OP_EN to flag opcodes 0xE/0xF on rsp_err.
module alu_arbiter import alu_pkg::*; #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]    req_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [XLEN-1:0]         rsp_data,
  output logic                    rsp_err
);

  logic [ID_W-1:0]    ptr_q, ptr_d, win_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               can_issue, accept;
  logic [XLEN-1:0]    op_a, op_b, alu_res, res_d;
  logic [3:0]         op_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(win_idx)
  );

  // rst_n gates issue so req_ready reads 0 while reset is held.
  assign can_issue = rst_n && (!rsp_valid || rsp_ready);
  assign req_ready = can_issue ? gnt : '0;
  assign accept    = |req_ready;
  assign ptr_d     = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_idx == ID_W'(i)) begin
        op_a   = req_a[i*XLEN +: XLEN];
        op_b   = req_b[i*XLEN +: XLEN];
        op_sel = req_sel[i*4 +: 4];
      end
    end
  end

  alu u_alu (
    .clk(clk),
    .rst_n(rst_n),
    .sel(op_sel),
    .dataA(op_a),
    .dataB(op_b),
    .dataD(alu_res)
  );

`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign res_d = is_illegal_op(op_sel) ? '0 : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (accept) begin
      rsp_err <= is_illegal_op(op_sel);
    end
  end
`else
  assign res_d   = alu_res;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      ptr_q     <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= win_idx;
      rsp_data  <= res_d;
      ptr_q     <= ptr_d;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold_chk
    assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[i] && !req_ready[i]) |=> (req_valid[i] &&
        $stable(req_a[i*XLEN +: XLEN]) && $stable(req_b[i*XLEN +: XLEN]) &&
        $stable(req_sel[i*4 +: 4])));
  end
`endif

endmodule
